// File: rtl/prt_dptx_pkg.sv
// Shared constants, FSM state type and the byte-wise CRC-32/MPEG-2 step
// used by the CRC_PIXELS generator.
package prt_dptx_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic {
        SYNC,
        ACC
    } crc_state_t;

    // Non-reflected, MSB-first: the byte enters at the top of the register.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {data, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/prt_dptx_crc_pixels_if.sv
// Video pixel bus feeding the CRC_PIXELS generator.
interface prt_dptx_crc_pixels_if #(
    parameter int DATA_W = 48
);
    logic              vid_vs;
    logic              vid_de;
    logic [DATA_W-1:0] vid_dat;

    modport master (output vid_vs, output vid_de, output vid_dat);
    modport slave  (input  vid_vs, input  vid_de, input  vid_dat);
endinterface

// File: rtl/prt_dptx_crc32_word.sv
// Combinational CRC-32/MPEG-2 update of one DATA_W-bit word, most
// significant byte folded first.
module prt_dptx_crc32_word
    import prt_dptx_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int b = DATA_W / 8 - 1; b >= 0; b--) begin
            c = crc32_byte(c, data[b*8 +: 8]);
        end
        crc_out = c;
    end

endmodule

// File: rtl/prt_dptx_crc_pixels.sv
// Per-frame CRC_PIXELS generator: folds every active pixel word into a CRC-32
// and publishes CRC, pixel count and count status on each vsync rising edge.
module prt_dptx_crc_pixels
    import prt_dptx_pkg::*;
#(
    parameter int PPC    = 2,
    parameter int BPC    = 8,
    parameter int DATA_W = PPC * BPC * 3,
    parameter int CNT_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prt_dptx_crc_pixels_if.slave vid,
    input  logic                 cfg_en,
    input  logic [CNT_W-1:0]     cfg_exp_pix,
    output logic [31:0]          crc_pixels,
    output logic                 crc_valid,
    output logic [CNT_W-1:0]     crc_pix_cnt,
    output logic                 crc_cnt_err,
    output logic [7:0]           crc_frame_cnt
);

    if ((DATA_W % 8) != 0 || BPC < 1) begin : g_bad_width
        $error("prt_dptx_crc_pixels: DATA_W must be a multiple of 8 and BPC positive");
    end

    crc_state_t       state;
    crc_state_t       state_next;
    logic             vs_q;
    logic             vs_rise;
    logic             pix_take;
    logic             publish;
    logic [31:0]      crc_acc;
    logic [31:0]      crc_step;
    logic [CNT_W-1:0] pix_acc;
    logic [CNT_W-1:0] pix_next;
    logic [CNT_W:0]   pix_sum;

    assign vs_rise  = vid.vid_vs & ~vs_q;
    assign pix_take = vid.vid_de & ~vid.vid_vs & cfg_en;
    assign publish  = (state == ACC) && cfg_en && vs_rise;

    // The extra carry bit lets the pixel count stick at all-ones instead of wrapping.
    assign pix_sum  = {1'b0, pix_acc} + (CNT_W + 1)'(PPC);
    assign pix_next = pix_sum[CNT_W] ? {CNT_W{1'b1}} : pix_sum[CNT_W-1:0];

    prt_dptx_crc32_word #(
        .DATA_W(DATA_W)
    ) u_crc_word (
        .crc_in (crc_acc),
        .data   (vid.vid_dat),
        .crc_out(crc_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (vs_rise && cfg_en) state_next = ACC;
            ACC:     if (!cfg_en) state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    // Accumulators restart at every frame boundary and whenever the frame is not
    // being tracked, so a partial frame never leaks into a published result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            crc_acc       <= CRC32_INIT;
            pix_acc       <= '0;
            crc_pixels    <= '0;
            crc_valid     <= 1'b0;
            crc_pix_cnt   <= '0;
            crc_cnt_err   <= 1'b0;
            crc_frame_cnt <= '0;
        end else begin
            vs_q      <= vid.vid_vs;
            crc_valid <= 1'b0;

            if (state == SYNC || !cfg_en || vs_rise) begin
                crc_acc <= CRC32_INIT;
                pix_acc <= '0;
            end else if (pix_take) begin
                crc_acc <= crc_step;
                pix_acc <= pix_next;
            end

            if (publish) begin
                crc_pixels    <= crc_acc;
                crc_pix_cnt   <= pix_acc;
                crc_cnt_err   <= (cfg_exp_pix != '0) && (pix_acc != cfg_exp_pix);
                crc_frame_cnt <= crc_frame_cnt + 8'd1;
                crc_valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prt_dptx_crc_pixels.sv
// Directed bench for prt_dptx_crc_pixels: a byte-wide build with a 4-bit
// counter and the 24-bit PPC=1 build, both driven from the same frame timing.
module tb_prt_dptx_crc_pixels;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [3:0]  exp8;
    logic [23:0] exp24;

    logic [31:0] crc8;
    logic        valid8;
    logic [3:0]  cnt8;
    logic        err8;
    logic [7:0]  frame8;

    logic [31:0] crc24;
    logic        valid24;
    logic [23:0] cnt24;
    logic        err24;
    logic [7:0]  frame24;

    int          total;
    int          bad;
    logic [71:0] msg;

    prt_dptx_crc_pixels_if #(.DATA_W(8))  vif8 ();
    prt_dptx_crc_pixels_if #(.DATA_W(24)) vif24 ();

    prt_dptx_crc_pixels #(
        .PPC(1), .BPC(8), .DATA_W(8), .CNT_W(4)
    ) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .vid          (vif8),
        .cfg_en       (cfg_en),
        .cfg_exp_pix  (exp8),
        .crc_pixels   (crc8),
        .crc_valid    (valid8),
        .crc_pix_cnt  (cnt8),
        .crc_cnt_err  (err8),
        .crc_frame_cnt(frame8)
    );

    prt_dptx_crc_pixels #(
        .PPC(1), .BPC(8), .CNT_W(24)
    ) dut24 (
        .clk          (clk),
        .rst_n        (rst_n),
        .vid          (vif24),
        .cfg_en       (cfg_en),
        .cfg_exp_pix  (exp24),
        .crc_pixels   (crc24),
        .crc_valid    (valid24),
        .crc_pix_cnt  (cnt24),
        .crc_cnt_err  (err24),
        .crc_frame_cnt(frame24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 ns after a rising edge and are sampled on the next one.
    task automatic applyStimulus(input logic vs, input logic de, input logic [23:0] dat);
        vif8.vid_vs   = vs;
        vif8.vid_de   = de;
        vif8.vid_dat  = dat[7:0];
        vif24.vid_vs  = vs;
        vif24.vid_de  = de;
        vif24.vid_dat = dat;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkPublish8(input string tag, input logic [3:0] cnt, input logic err,
                                 input logic [7:0] frame);
        checkOutput({tag, ".valid"}, {31'b0, valid8}, 32'd1);
        checkOutput({tag, ".cnt"},   {28'b0, cnt8},   {28'b0, cnt});
        checkOutput({tag, ".err"},   {31'b0, err8},   {31'b0, err});
        checkOutput({tag, ".frame"}, {24'b0, frame8}, {24'b0, frame});
    endtask

    // Second vsync-high cycle carries junk with de=1, which must not be folded in.
    task automatic holdCheck8(input string tag, input logic [31:0] crc);
        applyStimulus(1'b1, 1'b1, 24'h5A5A5A);
        checkOutput({tag, ".pulse_end"}, {31'b0, valid8}, 32'd0);
        checkOutput({tag, ".crc_held"},  crc8,           crc);
    endtask

    task automatic sendMsg();
        for (int i = 8; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, {16'h0000, msg[i*8 +: 8]});
        end
    endtask

    task automatic sendBytes(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 24'(i + 32'h40));
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        msg    = "123456789";
        rst_n  = 1'b0;
        cfg_en = 1'b1;
        exp8   = 4'd0;
        exp24  = 24'd0;
        vif8.vid_vs  = 1'b0; vif8.vid_de  = 1'b0; vif8.vid_dat  = '0;
        vif24.vid_vs = 1'b0; vif24.vid_de = 1'b0; vif24.vid_dat = '0;
        repeat (2) tick();

        $display("[TB] reset state");
        checkOutput("rst.crc",   crc8,            32'd0);
        checkOutput("rst.valid", {31'b0, valid8}, 32'd0);
        checkOutput("rst.cnt",   {28'b0, cnt8},   32'd0);
        checkOutput("rst.err",   {31'b0, err8},   32'd0);
        checkOutput("rst.frame", {24'b0, frame8}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] partial frame after reset is discarded");
        sendBytes(3);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkOutput("sync.valid", {31'b0, valid8}, 32'd0);
        checkOutput("sync.crc",   crc8,            32'd0);
        checkOutput("sync.frame", {24'b0, frame8}, 32'd0);
        applyStimulus(1'b0, 1'b0, 24'h0);

        $display("[TB] check string 123456789");
        sendMsg();
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("msg", 4'd9, 1'b0, 8'd1);
        checkOutput("msg.crc", crc8, 32'h0376E6E7);
        holdCheck8("msg", 32'h0376E6E7);

        $display("[TB] de during vsync and on the edge cycle is ignored");
        sendMsg();
        applyStimulus(1'b1, 1'b1, 24'h00FFEE);
        checkPublish8("msg_de_vs", 4'd9, 1'b0, 8'd2);
        checkOutput("msg_de_vs.crc", crc8, 32'h0376E6E7);
        holdCheck8("msg_de_vs", 32'h0376E6E7);

        $display("[TB] frame without active pixels");
        repeat (3) applyStimulus(1'b0, 1'b0, 24'h0);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("empty", 4'd0, 1'b0, 8'd3);
        checkOutput("empty.crc", crc8, 32'hFFFFFFFF);
        holdCheck8("empty", 32'hFFFFFFFF);

        $display("[TB] pixel count check: one short, then exact");
        exp8 = 4'd10;
        sendMsg();
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("short", 4'd9, 1'b1, 8'd4);
        holdCheck8("short", 32'h0376E6E7);
        exp8 = 4'd9;
        sendMsg();
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("exact", 4'd9, 1'b0, 8'd5);
        holdCheck8("exact", 32'h0376E6E7);

        $display("[TB] pixel counter saturation");
        sendMsg();
        sendMsg();
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("sat", 4'd15, 1'b1, 8'd6);

        $display("[TB] vsync stuck high");
        repeat (10) applyStimulus(1'b1, 1'b1, 24'h123456);
        checkOutput("stuck.valid", {31'b0, valid8}, 32'd0);
        checkOutput("stuck.frame", {24'b0, frame8}, 32'd6);
        checkOutput("stuck.cnt",   {28'b0, cnt8},   32'd15);

        $display("[TB] cfg_en dropped mid-frame");
        applyStimulus(1'b0, 1'b0, 24'h0);
        sendBytes(3);
        cfg_en = 1'b0;
        sendBytes(3);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkOutput("off.valid", {31'b0, valid8}, 32'd0);
        checkOutput("off.frame", {24'b0, frame8}, 32'd6);
        checkOutput("off.cnt",   {28'b0, cnt8},   32'd15);
        checkOutput("off.err",   {31'b0, err8},   32'd1);

        $display("[TB] re-enable publishes on the second edge");
        applyStimulus(1'b0, 1'b0, 24'h0);
        cfg_en = 1'b1;
        sendBytes(2);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkOutput("reen1.valid", {31'b0, valid8}, 32'd0);
        checkOutput("reen1.frame", {24'b0, frame8}, 32'd6);
        applyStimulus(1'b0, 1'b0, 24'h0);
        sendMsg();
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("reen2", 4'd9, 1'b0, 8'd7);
        checkOutput("reen2.crc", crc8, 32'h0376E6E7);
        holdCheck8("reen2", 32'h0376E6E7);

        $display("[TB] frame counter wrap");
        for (int i = 0; i < 248; i++) begin
            applyStimulus(1'b0, 1'b0, 24'h0);
            applyStimulus(1'b1, 1'b0, 24'h0);
        end
        checkOutput("wrap.frame255", {24'b0, frame8}, 32'd255);
        applyStimulus(1'b0, 1'b0, 24'h0);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkPublish8("wrap", 4'd0, 1'b1, 8'd0);
        checkOutput("wrap.crc", crc8, 32'hFFFFFFFF);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b0, 24'h0);
        sendBytes(3);
        rst_n = 1'b0;
        tick();
        checkOutput("rst2.crc",   crc8,            32'd0);
        checkOutput("rst2.valid", {31'b0, valid8}, 32'd0);
        checkOutput("rst2.cnt",   {28'b0, cnt8},   32'd0);
        checkOutput("rst2.err",   {31'b0, err8},   32'd0);
        checkOutput("rst2.frame", {24'b0, frame8}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] 24-bit word build, three bytes per clock");
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkOutput("w24.sync_valid", {31'b0, valid24}, 32'd0);
        applyStimulus(1'b0, 1'b0, 24'h0);
        applyStimulus(1'b0, 1'b1, 24'h313233);
        applyStimulus(1'b0, 1'b1, 24'h343536);
        applyStimulus(1'b0, 1'b1, 24'h373839);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkOutput("w24.valid", {31'b0, valid24}, 32'd1);
        checkOutput("w24.crc",   crc24,            32'h0376E6E7);
        checkOutput("w24.cnt",   {8'b0, cnt24},    32'd3);
        checkOutput("w24.err",   {31'b0, err24},   32'd0);
        checkOutput("w24.frame", {24'b0, frame24}, 32'd1);
        checkOutput("w24.frame8_after_reset", {24'b0, frame8}, 32'd1);
        applyStimulus(1'b1, 1'b0, 24'h0);
        checkOutput("w24.pulse_end", {31'b0, valid24}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
